// File: rtl/calc_display_if.sv
// calc_display_if: calculator-result capture and panel digit-bus bundle.
// Latency: none, wires only.
// Backpressure: busy tells the producer when a new load would be dropped.
interface calc_display_if;
  logic [26:0] value_in;
  logic        neg_in;
  logic        load;
  logic [1:0]  status;
  logic        busy;
  logic [3:0]  pos;
  logic [3:0]  data;

  // Calculator side drives the result, panel side drives the scan bus.
  modport master (output value_in, neg_in, load, status, input busy, pos, data);
  modport slave  (input value_in, neg_in, load, status, output busy, pos, data);
endinterface

// File: rtl/calc_display.sv
// calc_display: captures a signed-magnitude result, converts it to BCD and scans it onto the panel.
// Latency: 28 cycles from an accepted load to the display update (27 shift + 1 commit).
// Backpressure: busy is high while converting; a load seen during busy is dropped, not queued.
module calc_display #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 50000
) (
  input  logic           i_clock,
  input  logic           i_reset,
  calc_display_if.slave  bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [3:0] G_MINUS = 4'hA;
  localparam logic [3:0] G_ERR   = 4'hE;
  localparam logic [3:0] G_BLANK = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_COMMIT} state_t;

  state_t                   r_state, w_state_nxt;
  logic [26:0]              r_bin;
  logic [BCD_W-1:0]         r_bcd;
  logic [4:0]               r_cnt;
  logic                     r_neg;
  logic                     r_ovf;
  logic [DIGITS-1:0][3:0]   r_disp;
  logic [DIV_W-1:0]         r_div;
  logic [3:0]               r_pos;

  logic                     w_busy, w_capture, w_shift, w_commit;
  logic [BCD_W-1:0]         w_bcd_adj;
  logic [DIGITS-1:0][3:0]   w_disp_nxt;
  logic [3:0]               w_msd;
  logic                     w_nonzero, w_err;
  logic [3:0]               w_slot, w_data;
  logic                     w_tick;

  // FSM state register
  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next state: 27 shift cycles then a single commit cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (bus.load) w_state_nxt = S_CONV;
      S_CONV:   if (r_cnt == 5'd26) w_state_nxt = S_COMMIT;
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: datapath enables and busy flag
  always_comb begin
    w_busy    = (r_state != S_IDLE);
    w_capture = (r_state == S_IDLE) && bus.load;
    w_shift   = (r_state == S_CONV);
    w_commit  = (r_state == S_COMMIT);
  end

  // Double-dabble correction: bump every nibble >= 5 before the shift
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
  end

  // Build the panel image from finished BCD: blanking, sign and error glyph
  always_comb begin
    w_msd     = '0;
    w_nonzero = |r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] != 4'd0) w_msd = 4'(i);
    end
    // A negative number filling every digit leaves no slot for the minus sign.
    w_err = r_ovf || (r_neg && w_nonzero && (w_msd == 4'(DIGITS-1)));
    for (int i = 0; i < DIGITS; i++) begin
      if (w_err)
        w_disp_nxt[i] = (i == 0) ? G_ERR : G_BLANK;
      else if (r_neg && w_nonzero && (i == int'(w_msd) + 1))
        w_disp_nxt[i] = G_MINUS;
      else if (i > int'(w_msd))
        w_disp_nxt[i] = G_BLANK;
      else
        w_disp_nxt[i] = r_bcd[i*4 +: 4];
    end
  end

  // Conversion datapath and display register
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_bin <= '0;
      r_bcd <= '0;
      r_cnt <= '0;
      r_neg <= 1'b0;
      r_ovf <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_disp[i] <= (i == 0) ? 4'h0 : G_BLANK;
    end else begin
      if (w_capture) begin
        r_bin <= bus.value_in;
        r_neg <= bus.neg_in;
        r_ovf <= (bus.value_in > 27'd99_999_999);
        r_bcd <= '0;
        r_cnt <= '0;
      end
      if (w_shift) begin
        {r_bcd, r_bin} <= {w_bcd_adj, r_bin} << 1;
        r_cnt          <= r_cnt + 5'd1;
      end
      if (w_commit) r_disp <= w_disp_nxt;
    end
  end

  assign w_tick = (r_div == DIV_W'(SCAN_DIV - 1));

  // Free-running scan divider and digit position, independent of the FSM
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div <= '0;
      r_pos <= '0;
    end else if (w_tick) begin
      r_div <= '0;
      r_pos <= (r_pos == 4'(DIGITS - 1)) ? 4'd0 : r_pos + 4'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  // Select the glyph for the current slot; ERRO status overrides the image
  always_comb begin
    w_slot = G_BLANK;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_pos == 4'(i)) w_slot = r_disp[i];
    end
    if (bus.status == 2'b00) w_data = (r_pos == 4'd0) ? G_ERR : G_BLANK;
    else                     w_data = w_slot;
  end

  assign bus.busy = w_busy;
  assign bus.pos  = r_pos;
  assign bus.data = w_data;
endmodule

// File: tb/tb_calc_display.sv
// tb_calc_display: directed vectors against calc_display with a short scan divider.
// Latency: checks the 28-cycle busy window and the per-slot dwell.
// Backpressure: exercises a load dropped while busy.
module tb_calc_display;
  localparam int DIGITS   = 8;
  localparam int SCAN_DIV = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  calc_display_if bus ();

  calc_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Walk one full refresh and collect the glyph seen at each slot (nibble i = slot i).
  task automatic sweep(input string tag, input logic [31:0] exp);
    logic [31:0] seen;
    int          dwell;
    int          p;
    seen  = 'x;
    dwell = 0;
    for (int c = 0; c < DIGITS * SCAN_DIV; c++) begin
      p = int'(bus.pos);
      if (p < DIGITS) seen[p*4 +: 4] = bus.data;
      if (p == 3) dwell++;
      step();
    end
    chk({tag, " slots"}, seen, exp);
    chk({tag, " dwell"}, dwell, SCAN_DIV);
  endtask

  // Issue a load and count busy cycles; optionally pulse a second load at busy cycle extra_at.
  task automatic do_load(input string tag, input logic [26:0] v, input logic n, input int extra_at);
    int cnt;
    cnt = 0;
    bus.value_in = v;
    bus.neg_in   = n;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    while (bus.busy === 1'b1 && cnt < 100) begin
      cnt++;
      if (cnt == extra_at) begin
        bus.value_in = 27'd5;
        bus.neg_in   = 1'b0;
        bus.load     = 1'b1;
      end else begin
        bus.load = 1'b0;
      end
      step();
    end
    bus.load = 1'b0;
    chk({tag, " busy"}, cnt, 28);
  endtask

  initial begin
    bus.value_in = '0;
    bus.neg_in   = 1'b0;
    bus.load     = 1'b0;
    bus.status   = 2'b01;
    rst          = 1'b1;
    step();
    step();
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst pos",  {28'd0, bus.pos},  32'd0);
    chk("rst data", {28'd0, bus.data}, 32'd0);
    rst = 1'b0;
    sweep("rst", 32'hFFFF_FFF0);

    do_load("1234", 27'd1234, 1'b0, -1);
    sweep("1234", 32'hFFFF_1234);

    do_load("-56", 27'd56, 1'b1, -1);
    sweep("-56", 32'hFFFF_FA56);

    do_load("-0", 27'd0, 1'b1, -1);
    sweep("-0", 32'hFFFF_FFF0);

    do_load("max", 27'd99_999_999, 1'b0, -1);
    sweep("max", 32'h9999_9999);

    do_load("ovf", 27'd100_000_000, 1'b0, -1);
    sweep("ovf", 32'hFFFF_FFFE);

    do_load("-1e7", 27'd10_000_000, 1'b1, -1);
    sweep("-1e7", 32'hFFFF_FFFE);

    do_load("777", 27'd777, 1'b0, 10);
    sweep("777", 32'hFFFF_F777);

    // Reset in the middle of a conversion restores the power-on image.
    bus.value_in = 27'd123;
    bus.neg_in   = 1'b0;
    bus.load     = 1'b1;
    step();
    bus.load = 1'b0;
    repeat (14) step();
    rst = 1'b1;
    step();
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst pos",  {28'd0, bus.pos},  32'd0);
    chk("midrst data", {28'd0, bus.data}, 32'd0);
    rst = 1'b0;
    repeat (30) step();
    chk("midrst idle", {31'd0, bus.busy}, 32'd0);
    sweep("midrst", 32'hFFFF_FFF0);

    do_load("42", 27'd42, 1'b0, -1);
    bus.status = 2'b00;
    sweep("erro", 32'hFFFF_FFFE);
    bus.status = 2'b01;
    sweep("pronta", 32'hFFFF_FF42);
    bus.status = 2'b11;
    sweep("st11", 32'hFFFF_FF42);
    bus.status = 2'b10;
    sweep("ocupada", 32'hFFFF_FF42);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
